// File: rtl/cv32e40p_pmp_unit.sv
// ==========================================================================
// cv32e40p_pmp_unit : RISC-V PMP checker, registered instr/data ports | rev 1.0
// ==========================================================================
`default_nettype none

module cv32e40p_pmp_unit #(
  parameter int unsigned PMP_NUM_REGIONS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  csr_idx_i,
  input  logic        csr_cfg_we_i,
  input  logic [7:0]  csr_cfg_i,
  input  logic        csr_addr_we_i,
  input  logic [31:0] csr_addr_i,
  output logic [7:0]  csr_cfg_o,
  output logic [31:0] csr_addr_o,
  input  logic        priv_m_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_valid_o,
  output logic        instr_access_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  output logic        data_valid_o,
  output logic        data_access_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o,
  output logic        fault_is_instr_o,
  input  logic        fault_clr_i
);

  localparam logic [1:0] c_A_OFF   = 2'd0;
  localparam logic [1:0] c_A_TOR   = 2'd1;
  localparam logic [1:0] c_A_NA4   = 2'd2;
  localparam logic [1:0] c_A_NAPOT = 2'd3;

  logic [7:0]  r_cfg  [PMP_NUM_REGIONS];
  logic [31:0] r_addr [PMP_NUM_REGIONS];
  logic [31:0] w_lo   [PMP_NUM_REGIONS];

  logic [PMP_NUM_REGIONS-1:0] w_cfg_wen;
  logic [PMP_NUM_REGIONS-1:0] w_addr_wen;
  logic [PMP_NUM_REGIONS-1:0] w_tor_lock;
  logic [PMP_NUM_REGIONS-1:0] w_tor_lock_nxt;

  logic [31:0] w_ia;
  logic [31:0] w_da;
  logic        w_i_allow;
  logic        w_d_allow;
  logic        w_i_deny;
  logic        w_d_deny;
  logic        w_unused;

  logic        r_i_valid;
  logic        r_i_access;
  logic        r_d_valid;
  logic        r_d_access;
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic        r_fault_is_instr;

  // Region addresses are word granular: compare pmpaddr against addr[31:2].
  assign w_ia     = {2'b00, instr_addr_i[31:2]};
  assign w_da     = {2'b00, data_addr_i[31:2]};
  assign w_unused = ^{instr_addr_i[1:0], data_addr_i[1:0], csr_cfg_i[6:5]};

  // p ^ (p+1) sets bits [k:0] where k is the trailing-ones count; all-ones gives a full mask.
  function automatic logic f_match(input logic [1:0]  mode,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi,
                                   input logic [31:0] a);
    logic [31:0] mask;
    mask = hi ^ (hi + 32'd1);
    case (mode)
      c_A_TOR:   f_match = (a >= lo) && (a < hi);
      c_A_NA4:   f_match = (a == hi);
      c_A_NAPOT: f_match = ((a ^ hi) & ~mask) == 32'd0;
      c_A_OFF:   f_match = 1'b0;
      default:   f_match = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] f_sanitize(input logic [7:0] d);
    logic [7:0] s;
    s    = {d[7], 2'b00, d[4:0]};
    s[1] = d[1] & d[0];
    return s;
  endfunction

  always_comb begin
    w_lo[0] = '0;
    for (int i = 1; i < int'(PMP_NUM_REGIONS); i++) begin
      w_lo[i] = r_addr[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(PMP_NUM_REGIONS); i++) begin
      w_tor_lock[i] = r_cfg[i][7] && (r_cfg[i][4:3] == c_A_TOR);
    end
  end

  assign w_tor_lock_nxt = w_tor_lock >> 1;

  // A locked TOR region also freezes the pmpaddr below it, since that is its lower bound.
  always_comb begin
    for (int i = 0; i < int'(PMP_NUM_REGIONS); i++) begin
      w_cfg_wen[i]  = csr_cfg_we_i && (csr_idx_i == 4'(i)) && !r_cfg[i][7];
      w_addr_wen[i] = csr_addr_we_i && (csr_idx_i == 4'(i)) && !r_cfg[i][7]
                      && !w_tor_lock_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PMP_NUM_REGIONS); i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(PMP_NUM_REGIONS); i++) begin
        if (w_cfg_wen[i])  r_cfg[i]  <= f_sanitize(csr_cfg_i);
        if (w_addr_wen[i]) r_addr[i] <= csr_addr_i;
      end
    end
  end

  always_comb begin
    csr_cfg_o  = '0;
    csr_addr_o = '0;
    for (int i = 0; i < int'(PMP_NUM_REGIONS); i++) begin
      if (csr_idx_i == 4'(i)) begin
        csr_cfg_o  = r_cfg[i];
        csr_addr_o = r_addr[i];
      end
    end
  end

  // Walk from the top so the lowest-indexed match is the last assignment and wins.
  always_comb begin
    w_i_allow = priv_m_i;
    w_d_allow = priv_m_i;
    for (int i = int'(PMP_NUM_REGIONS) - 1; i >= 0; i--) begin
      if (f_match(r_cfg[i][4:3], w_lo[i], r_addr[i], w_ia)) begin
        w_i_allow = (priv_m_i && !r_cfg[i][7]) || r_cfg[i][2];
      end
      if (f_match(r_cfg[i][4:3], w_lo[i], r_addr[i], w_da)) begin
        w_d_allow = (priv_m_i && !r_cfg[i][7]) ||
                    (data_we_i ? r_cfg[i][1] : r_cfg[i][0]);
      end
    end
  end

  assign w_i_deny = instr_req_i && !w_i_allow;
  assign w_d_deny = data_req_i && !w_d_allow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_valid  <= 1'b0;
      r_i_access <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_access <= 1'b0;
    end else begin
      r_i_valid  <= instr_req_i;
      r_i_access <= instr_req_i && w_i_allow;
      r_d_valid  <= data_req_i;
      r_d_access <= data_req_i && w_d_allow;
    end
  end

  // A new denial beats a same-cycle clear; the instruction side wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault          <= 1'b0;
      r_fault_addr     <= '0;
      r_fault_is_instr <= 1'b0;
    end else if ((!r_fault || fault_clr_i) && (w_i_deny || w_d_deny)) begin
      r_fault          <= 1'b1;
      r_fault_addr     <= w_i_deny ? instr_addr_i : data_addr_i;
      r_fault_is_instr <= w_i_deny;
    end else if (fault_clr_i) begin
      r_fault          <= 1'b0;
    end
  end

  assign instr_valid_o    = r_i_valid;
  assign instr_access_o   = r_i_access;
  assign data_valid_o     = r_d_valid;
  assign data_access_o    = r_d_access;
  assign fault_o          = r_fault;
  assign fault_addr_o     = r_fault_addr;
  assign fault_is_instr_o = r_fault_is_instr;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_pmp_unit.sv
// ==========================================================================
// tb_cv32e40p_pmp_unit : directed self-checking bench for the PMP unit | rev 1.0
// ==========================================================================
`default_nettype none

module tb_cv32e40p_pmp_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  csr_idx_i;
  logic        csr_cfg_we_i;
  logic [7:0]  csr_cfg_i;
  logic        csr_addr_we_i;
  logic [31:0] csr_addr_i;
  logic [7:0]  csr_cfg_o;
  logic [31:0] csr_addr_o;
  logic        priv_m_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_valid_o;
  logic        instr_access_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic        data_valid_o;
  logic        data_access_o;
  logic        fault_o;
  logic [31:0] fault_addr_o;
  logic        fault_is_instr_o;
  logic        fault_clr_i;

  int checks;
  int errors;

  cv32e40p_pmp_unit #(.PMP_NUM_REGIONS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_idx_i       (csr_idx_i),
    .csr_cfg_we_i    (csr_cfg_we_i),
    .csr_cfg_i       (csr_cfg_i),
    .csr_addr_we_i   (csr_addr_we_i),
    .csr_addr_i      (csr_addr_i),
    .csr_cfg_o       (csr_cfg_o),
    .csr_addr_o      (csr_addr_o),
    .priv_m_i        (priv_m_i),
    .instr_req_i     (instr_req_i),
    .instr_addr_i    (instr_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_access_o  (instr_access_o),
    .data_req_i      (data_req_i),
    .data_addr_i     (data_addr_i),
    .data_we_i       (data_we_i),
    .data_valid_o    (data_valid_o),
    .data_access_o   (data_access_o),
    .fault_o         (fault_o),
    .fault_addr_o    (fault_addr_o),
    .fault_is_instr_o(fault_is_instr_o),
    .fault_clr_i     (fault_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request cycle; returns at the negedge after the result has been registered.
  task automatic issue(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic [31:0] daddr,
                       input logic dwe, input logic pm);
    @(negedge clk);
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_addr_i  = daddr;
    data_we_i    = dwe;
    priv_m_i     = pm;
    @(negedge clk);
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
  endtask

  task automatic cfg_wr(input logic [3:0] idx, input logic [7:0] val);
    @(negedge clk);
    csr_idx_i    = idx;
    csr_cfg_i    = val;
    csr_cfg_we_i = 1'b1;
    @(negedge clk);
    csr_cfg_we_i = 1'b0;
  endtask

  task automatic addr_wr(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    csr_idx_i     = idx;
    csr_addr_i    = val;
    csr_addr_we_i = 1'b1;
    @(negedge clk);
    csr_addr_we_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    csr_idx_i = 4'd0;
    #1;
    checks++;
    if ({instr_valid_o, instr_access_o, data_valid_o, data_access_o, fault_o, fault_is_instr_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
        {instr_valid_o, instr_access_o, data_valid_o, data_access_o, fault_o, fault_is_instr_o});
    end
    checks++;
    if ({fault_addr_o, csr_addr_o, csr_cfg_o} !== 72'd0) begin
      errors++; $display("FAIL reset_regs fault_addr %h addr %h cfg %h exp 0", fault_addr_o, csr_addr_o, csr_cfg_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
    checks++;
    if ({data_valid_o, data_access_o, fault_o, fault_is_instr_o} !== 4'b1010) begin
      errors++; $display("FAIL reset_u_load valid/access/fault/isinstr got %b exp 1010",
        {data_valid_o, data_access_o, fault_o, fault_is_instr_o});
    end
    checks++;
    if (fault_addr_o !== 32'h0000_1000) begin
      errors++; $display("FAIL reset_u_load_addr got %h exp 00001000", fault_addr_o);
    end
    issue(1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    checks++;
    if ({instr_valid_o, instr_access_o, data_valid_o, data_access_o} !== 4'b1111) begin
      errors++; $display("FAIL reset_m_allow got %b exp 1111",
        {instr_valid_o, instr_access_o, data_valid_o, data_access_o});
    end
    checks++;
    if (fault_addr_o !== 32'h0000_1000) begin
      errors++; $display("FAIL fault_sticky got %h exp 00001000", fault_addr_o);
    end
    @(negedge clk);
    checks++;
    if ({instr_valid_o, instr_access_o, data_valid_o, data_access_o} !== 4'b0000) begin
      errors++; $display("FAIL idle_outputs got %b exp 0000",
        {instr_valid_o, instr_access_o, data_valid_o, data_access_o});
    end
  endtask

  task automatic test_napot();
    do_reset();
    addr_wr(4'd0, 32'h0000_01FF);
    cfg_wr(4'd0, 8'h1B);
    csr_idx_i = 4'd0;
    #1;
    checks++;
    if ({csr_cfg_o, csr_addr_o} !== {8'h1B, 32'h0000_01FF}) begin
      errors++; $display("FAIL napot_readback cfg %h addr %h exp 1b 000001ff", csr_cfg_o, csr_addr_o);
    end
    issue(1'b0, 32'h0, 1'b1, 32'h0000_0FFC, 1'b1, 1'b0);
    checks++;
    if (data_access_o !== 1'b1) begin
      errors++; $display("FAIL napot_st_0ffc got %b exp 1", data_access_o);
    end
    issue(1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
    checks++;
    if (data_access_o !== 1'b0) begin
      errors++; $display("FAIL napot_st_1000 got %b exp 0", data_access_o);
    end
    issue(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({instr_valid_o, instr_access_o} !== 2'b10) begin
      errors++; $display("FAIL napot_fetch_0010 got %b exp 10", {instr_valid_o, instr_access_o});
    end
  endtask

  task automatic test_tor();
    do_reset();
    addr_wr(4'd0, 32'h0000_0400);
    addr_wr(4'd1, 32'h0000_0800);
    cfg_wr(4'd1, 8'h0D);
    issue(1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (instr_access_o !== 1'b1) begin
      errors++; $display("FAIL tor_fetch_1000 got %b exp 1", instr_access_o);
    end
    issue(1'b1, 32'h0000_1FFC, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (instr_access_o !== 1'b1) begin
      errors++; $display("FAIL tor_fetch_1ffc got %b exp 1", instr_access_o);
    end
    issue(1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (instr_access_o !== 1'b0) begin
      errors++; $display("FAIL tor_fetch_2000 got %b exp 0", instr_access_o);
    end
    issue(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (instr_access_o !== 1'b0) begin
      errors++; $display("FAIL tor_fetch_0ffc got %b exp 0", instr_access_o);
    end
    issue(1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b1, 1'b1);
    checks++;
    if (data_access_o !== 1'b1) begin
      errors++; $display("FAIL tor_m_store_unlocked got %b exp 1", data_access_o);
    end
    cfg_wr(4'd2, 8'h7E);
    cfg_wr(4'd4, 8'h1F);
    csr_idx_i = 4'd2;
    #1;
    checks++;
    if (csr_cfg_o !== 8'h1C) begin
      errors++; $display("FAIL cfg_sanitize got %h exp 1c", csr_cfg_o);
    end
    csr_idx_i = 4'd0;
    #1;
    checks++;
    if (csr_cfg_o !== 8'h00) begin
      errors++; $display("FAIL cfg_idx_out_of_range got %h exp 00", csr_cfg_o);
    end
  endtask

  task automatic test_lock();
    cfg_wr(4'd1, 8'h8D);
    addr_wr(4'd0, 32'h0000_0FFF);
    addr_wr(4'd1, 32'h0000_0000);
    cfg_wr(4'd1, 8'h00);
    addr_wr(4'd2, 32'h0000_0005);
    csr_idx_i = 4'd0;
    #1;
    checks++;
    if (csr_addr_o !== 32'h0000_0400) begin
      errors++; $display("FAIL lock_addr0 got %h exp 00000400", csr_addr_o);
    end
    csr_idx_i = 4'd1;
    #1;
    checks++;
    if ({csr_cfg_o, csr_addr_o} !== {8'h8D, 32'h0000_0800}) begin
      errors++; $display("FAIL lock_region1 cfg %h addr %h exp 8d 00000800", csr_cfg_o, csr_addr_o);
    end
    csr_idx_i = 4'd2;
    #1;
    checks++;
    if (csr_addr_o !== 32'h0000_0005) begin
      errors++; $display("FAIL unlocked_addr2 got %h exp 00000005", csr_addr_o);
    end
    issue(1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b1, 1'b1);
    checks++;
    if (data_access_o !== 1'b0) begin
      errors++; $display("FAIL lock_m_store got %b exp 0", data_access_o);
    end
    issue(1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0, 1'b1);
    checks++;
    if (data_access_o !== 1'b1) begin
      errors++; $display("FAIL lock_m_load got %b exp 1", data_access_o);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    addr_wr(4'd0, 32'h0000_0100);
    cfg_wr(4'd0, 8'h10);
    addr_wr(4'd1, 32'hFFFF_FFFF);
    cfg_wr(4'd1, 8'h1F);
    issue(1'b0, 32'h0, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
    checks++;
    if (data_access_o !== 1'b0) begin
      errors++; $display("FAIL overlap_load_0400 got %b exp 0", data_access_o);
    end
    issue(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0404, 1'b0, 1'b0);
    checks++;
    if ({instr_access_o, data_access_o} !== 2'b11) begin
      errors++; $display("FAIL overlap_fetch_top_load_0404 got %b exp 11", {instr_access_o, data_access_o});
    end
    issue(1'b0, 32'h0, 1'b1, 32'h0000_0400, 1'b0, 1'b1);
    checks++;
    if (data_access_o !== 1'b1) begin
      errors++; $display("FAIL overlap_m_unlocked got %b exp 1", data_access_o);
    end
  endtask

  task automatic test_concurrent_fault();
    do_reset();
    issue(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    checks++;
    if ({instr_valid_o, instr_access_o, data_valid_o, data_access_o, fault_o, fault_is_instr_o} !== 6'b101011) begin
      errors++; $display("FAIL dual_deny flags got %b exp 101011",
        {instr_valid_o, instr_access_o, data_valid_o, data_access_o, fault_o, fault_is_instr_o});
    end
    checks++;
    if (fault_addr_o !== 32'h0000_0020) begin
      errors++; $display("FAIL dual_deny_addr got %h exp 00000020", fault_addr_o);
    end
    issue(1'b0, 32'h0, 1'b1, 32'h0000_0060, 1'b0, 1'b0);
    checks++;
    if ({fault_addr_o, fault_is_instr_o} !== {32'h0000_0020, 1'b1}) begin
      errors++; $display("FAIL no_overwrite got %h/%b exp 00000020/1", fault_addr_o, fault_is_instr_o);
    end
    fault_clr_i = 1'b1;
    issue(1'b0, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    fault_clr_i = 1'b0;
    checks++;
    if ({fault_o, fault_addr_o, fault_is_instr_o} !== {1'b1, 32'h0000_0080, 1'b0}) begin
      errors++; $display("FAIL clr_with_deny got %b/%h/%b exp 1/00000080/0", fault_o, fault_addr_o, fault_is_instr_o);
    end
    fault_clr_i = 1'b1;
    issue(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b1);
    fault_clr_i = 1'b0;
    checks++;
    if ({fault_o, instr_access_o} !== 2'b01) begin
      errors++; $display("FAIL clr_alone fault/access got %b exp 01", {fault_o, instr_access_o});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    addr_wr(4'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    csr_idx_i    = 4'd0;
    csr_cfg_i    = 8'h1F;
    csr_cfg_we_i = 1'b1;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h0000_0500;
    data_we_i    = 1'b0;
    priv_m_i     = 1'b0;
    @(negedge clk);
    csr_cfg_we_i = 1'b0;
    checks++;
    if ({data_valid_o, data_access_o} !== 2'b10) begin
      errors++; $display("FAIL same_cycle_prewrite got %b exp 10", {data_valid_o, data_access_o});
    end
    @(negedge clk);
    data_req_i = 1'b0;
    checks++;
    if ({data_valid_o, data_access_o} !== 2'b11) begin
      errors++; $display("FAIL next_cycle_postwrite got %b exp 11", {data_valid_o, data_access_o});
    end
    @(negedge clk);
    checks++;
    if ({data_valid_o, data_access_o} !== 2'b00) begin
      errors++; $display("FAIL b2b_drop got %b exp 00", {data_valid_o, data_access_o});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_wr(4'd0, 8'h9F);
    cfg_wr(4'd0, 8'h00);
    csr_idx_i = 4'd0;
    #1;
    checks++;
    if (csr_cfg_o !== 8'h9F) begin
      errors++; $display("FAIL lock_cfg_hold got %h exp 9f", csr_cfg_o);
    end
    @(negedge clk);
    data_req_i  = 1'b1;
    data_addr_i = 32'h0000_0004;
    data_we_i   = 1'b0;
    priv_m_i    = 1'b0;
    @(negedge clk);
    data_req_i = 1'b0;
    checks++;
    if ({data_valid_o, data_access_o} !== 2'b11) begin
      errors++; $display("FAIL inflight_before_reset got %b exp 11", {data_valid_o, data_access_o});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_valid_o, data_access_o, csr_cfg_o} !== 10'd0) begin
      errors++; $display("FAIL async_reset_mid got %b/%h exp 00/00", {data_valid_o, data_access_o}, csr_cfg_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    csr_idx_i     = '0;
    csr_cfg_we_i  = 1'b0;
    csr_cfg_i     = '0;
    csr_addr_we_i = 1'b0;
    csr_addr_i    = '0;
    priv_m_i      = 1'b0;
    instr_req_i   = 1'b0;
    instr_addr_i  = '0;
    data_req_i    = 1'b0;
    data_addr_i   = '0;
    data_we_i     = 1'b0;
    fault_clr_i   = 1'b0;

    test_reset();
    test_napot();
    test_tor();
    test_lock();
    test_overlap();
    test_concurrent_fault();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cv32e40p_pmp_unit.md
CV32E40P_PMP_UNIT -- requirements
Module: cv32e40p_pmp_unit

Interface
REQ-001 SHALL provide parameter PMP_NUM_REGIONS, default 4, number of regions, legal range 1..16.
REQ-002 SHALL provide ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL provide ports: csr_idx_i  in  4  target region; csr_cfg_we_i  in  1  cfg write strobe; csr_cfg_i  in  8  cfg data; csr_addr_we_i  in  1  pmpaddr write strobe; csr_addr_i  in  32  pmpaddr data.
REQ-004 SHALL provide ports: csr_cfg_o  out  8  cfg of csr_idx_i; csr_addr_o  out  32  pmpaddr of csr_idx_i (combinational read, 0 if idx >= PMP_NUM_REGIONS).
REQ-005 SHALL provide ports: priv_m_i  in  1  1 = machine mode, 0 = user mode.
REQ-006 SHALL provide ports: instr_req_i  in  1; instr_addr_i  in  32; instr_valid_o  out  1; instr_access_o  out  1 (1 = allowed).
REQ-007 SHALL provide ports: data_req_i  in  1; data_addr_i  in  32; data_we_i  in  1 (1 = store); data_valid_o  out  1; data_access_o  out  1.
REQ-008 SHALL provide ports: fault_o  out  1  sticky violation flag; fault_addr_o  out  32  first faulting address; fault_is_instr_o  out  1; fault_clr_i  in  1  clears capture.

Function
REQ-009 cfg byte fields SHALL be: [0] R, [1] W, [2] X, [4:3] A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), [7] L; bits [6:5] SHALL be stored as 0.
REQ-010 pmpaddr SHALL encode byte address bits [33:2]; comparisons use {2'b00, addr[31:2]}.
REQ-011 TOR SHALL match when pmpaddr[i-1] <= a < pmpaddr[i]; region 0 lower bound is 0; bound[i-1] >= bound[i] SHALL yield no match.
REQ-012 NA4 SHALL match when a == pmpaddr[i].
REQ-013 NAPOT: with k = count of trailing ones in pmpaddr[i], SHALL match a 2^(k+3)-byte region whose base is pmpaddr[i] with its k+1 low bits cleared; all-ones pmpaddr SHALL match the full 4 GiB.
REQ-014 The lowest-indexed matching region SHALL alone decide; the required permission is X for fetch, W for store, and R for load.
REQ-015 With no matching region, M mode SHALL be allowed and U mode SHALL be denied.
REQ-016 A matching region SHALL govern U mode always; it SHALL govern M mode only when L=1, otherwise M mode is allowed.
REQ-017 Writes with csr_idx_i >= PMP_NUM_REGIONS SHALL be ignored.
REQ-018 Writes to cfg[i] or pmpaddr[i] SHALL be ignored while cfg[i].L=1.
REQ-019 A write to pmpaddr[i] SHALL be ignored while cfg[i+1].L=1 and cfg[i+1].A=TOR.
REQ-020 cfg write data with A=NA4 and PMP_NUM_REGIONS... SHALL be stored as given; W=1 with R=0 SHALL be stored with W forced to 0.
REQ-021 Checks SHALL be registered: *_valid_o = *_req_i delayed one cycle; *_access_o is the result for the address sampled on that edge and SHALL be 0 when *_valid_o=0.
REQ-022 Instruction and data checks SHALL proceed independently and concurrently in the same cycle.
REQ-023 A CSR write and a check in the same cycle SHALL evaluate the check against pre-write state; the new state applies from the next cycle.
REQ-024 On the first denied result while fault_o=0, the block SHALL set fault_o and capture fault_addr_o and fault_is_instr_o; later faults SHALL NOT overwrite the capture.
REQ-025 Simultaneous instruction and data denials SHALL capture the instruction address.
REQ-026 fault_clr_i SHALL clear fault_o in the next cycle; a denial in the same cycle as fault_clr_i SHALL be captured, since the new fault takes priority over the clear.

Reset
REQ-027 rst_n low SHALL asynchronously clear all cfg, pmpaddr, *_valid_o, *_access_o, fault_o, fault_addr_o, and fault_is_instr_o to 0.
REQ-028 After reset, because all regions are OFF, an M-mode access SHALL be allowed and a U-mode access SHALL be denied.
REQ-029 Asserting reset mid-operation SHALL clear locks and discard any in-flight check result.

Verification
REQ-030 Reset, U-mode load to 0x0000_1000 -> next cycle data_valid_o=1, data_access_o=0, fault_o=1, fault_addr_o=0x0000_1000.
REQ-031 Region0 NAPOT pmpaddr=0x0000_01FF (4 KiB at 0x0) cfg=0x1B (R,W,NAPOT); U store 0x0FFC -> allow; 0x1000 -> deny; U fetch 0x0010 -> deny.
REQ-032 Region0 pmpaddr=0x400, region1 TOR pmpaddr=0x800 cfg=0x0D (R,X); U fetch 0x1000 and 0x1FFC -> allow; 0x2000 -> deny; 0x0FFC -> deny.
REQ-033 Region1 cfg=0x8D (locked TOR); write pmpaddr0=0xFFF, pmpaddr1=0x0, and cfg1=0 -> all unchanged; M-mode store 0x1000 -> deny.
REQ-034 Overlap: region0 NA4 at 0x100 cfg=0x10 (no perm), region1 NAPOT full space cfg=0x1F; U load 0x400 -> deny; 0x404 -> allow.
REQ-035 Same-cycle instr deny 0x20 and data deny 0x40 -> fault_addr_o=0x20, fault_is_instr_o=1; fault_clr_i plus a new deny at 0x80 -> fault_addr_o=0x80.
